// File: rtl/npc_mem_pkg.sv
// Shared definitions for the pmem bridge: FSM state encoding and the
// pmem_read/pmem_write memory calls, with bookkeeping of the last call made.
package npc_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } bridge_state_e;

    // Sparse backing store keyed by the aligned byte address
    logic [63:0] pmem_mem [logic [63:0]];
    int unsigned pmem_rd_cnt;
    int unsigned pmem_wr_cnt;
    logic [63:0] pmem_rd_addr;
    logic [63:0] pmem_wr_addr;

    function automatic logic [63:0] pmem_read(input logic [63:0] addr);
        pmem_rd_cnt  = pmem_rd_cnt + 1;
        pmem_rd_addr = addr;
        return pmem_mem.exists(addr) ? pmem_mem[addr] : 64'h0;
    endfunction

    function automatic void pmem_write(input logic [63:0] addr, input logic [63:0] data,
                                       input logic [7:0] mask);
        logic [63:0] word;
        pmem_wr_cnt  = pmem_wr_cnt + 1;
        pmem_wr_addr = addr;
        word = pmem_mem.exists(addr) ? pmem_mem[addr] : 64'h0;
        for (int b = 0; b < 8; b++) begin
            if (mask[b]) word[b*8 +: 8] = data[b*8 +: 8];
        end
        pmem_mem[addr] = word;
    endfunction

    function automatic void pmem_load(input logic [63:0] addr, input logic [63:0] data);
        pmem_mem[addr] = data;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant among asserted requests, search starting
// just after the last granted index; pointer moves only when advance is high.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] last_q, last_d;
    logic          found;
    int            idx;

    always_comb begin
        grant  = '0;
        last_d = last_q;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last_q) + k) % N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
                if (advance) last_d = PW'(idx);
            end
        end
    end

    // Starting at N-1 makes channel 0 the first winner after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_q <= PW'(N - 1);
        else     last_q <= last_d;
    end

endmodule

// File: rtl/pmem_bridge.sv
// Multi-channel bridge to a single memory port: arbitrates requesters, issues
// one memory call per accepted request and returns a one-cycle response.
//
//   state   | meaning
//   IDLE    | no transaction outstanding, arbiter grant drives req_ready
//   WAIT    | memory call done, counting down the remaining latency
//   RESP    | last busy cycle; response registered for the latched channel
module pmem_bridge
    import npc_mem_pkg::*;
#(
    parameter int NPORT   = 2,
    parameter int AW      = 64,
    parameter int DW      = 64,
    parameter int LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NPORT-1:0]       req_valid,
    output logic [NPORT-1:0]       req_ready,
    input  logic [NPORT-1:0]       req_write,
    input  logic [NPORT*AW-1:0]    req_addr,
    input  logic [NPORT*DW-1:0]    req_wdata,
    input  logic [NPORT*DW/8-1:0]  req_wmask,
    output logic [NPORT-1:0]       rsp_valid,
    output logic [NPORT*DW-1:0]    rsp_rdata,
    output logic                   busy
);
    localparam int MW  = DW / 8;
    localparam int CHW = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int CW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [AW-1:0] ALIGN_MASK = ~AW'(MW - 1);
    localparam logic [CW-1:0] CNT_LOAD   = CW'((LATENCY > 1) ? LATENCY - 2 : 0);

    bridge_state_e       state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [CHW-1:0]      ch_q, ch_d;
    logic                wr_q, wr_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [DW-1:0]       wdata_q, wdata_d;
    logic [MW-1:0]       wmask_q, wmask_d;
    logic [DW-1:0]       rd_buf_q;
    logic [NPORT-1:0]    rsp_valid_q, rsp_valid_d;
    logic [NPORT*DW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [NPORT-1:0]    grant;
    logic                accept;
    int                  gidx;

    rr_arbiter #(.N(NPORT)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (accept),
        .grant   (grant)
    );

    always_comb begin
        gidx = 0;
        for (int i = 0; i < NPORT; i++) begin
            if (grant[i]) gidx = i;
        end
        req_ready = (state_q == ST_IDLE && !rst) ? grant : '0;
        accept    = |(req_valid & req_ready);

        state_d     = state_q;
        cnt_d       = cnt_q;
        ch_d        = ch_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    ch_d    = CHW'(gidx);
                    wr_d    = req_write[gidx];
                    addr_d  = req_addr[gidx*AW +: AW] & ALIGN_MASK;
                    wdata_d = req_wdata[gidx*DW +: DW];
                    wmask_d = req_wmask[gidx*MW +: MW];
                    cnt_d   = CNT_LOAD;
                    state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) state_d = ST_RESP;
                else             cnt_d   = cnt_q - CW'(1);
            end
            ST_RESP: begin
                rsp_valid_d[ch_q]                = 1'b1;
                rsp_rdata_d[int'(ch_q)*DW +: DW] = wr_q ? '0 : rd_buf_q;
                state_d                          = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy = (state_q != ST_IDLE);
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

    // Memory calls use the _d fields so they fire on the accept edge itself
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ch_q        <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            rd_buf_q    <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ch_q        <= ch_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            if (accept) begin
                if (!wr_d)
                    rd_buf_q <= DW'(pmem_read(64'(addr_d)));
                else if (|wmask_d)
                    pmem_write(64'(addr_d), 64'(wdata_d), 8'(wmask_d));
            end
        end
    end

endmodule

// File: tb/tb_pmem_bridge.sv
// Directed bench for pmem_bridge: a 2-channel/LATENCY=2 instance and a
// 3-channel/LATENCY=1 instance, checked against hand-computed values.
module tb_pmem_bridge;
    import npc_mem_pkg::*;

    logic         clk;
    logic         rst;
    logic [1:0]   req_valid, req_ready, req_write, rsp_valid;
    logic [127:0] req_addr, req_wdata, rsp_rdata;
    logic [15:0]  req_wmask;
    logic         busy;

    logic [2:0]   b_req_valid, b_req_ready, b_req_write, b_rsp_valid;
    logic [191:0] b_req_addr, b_req_wdata, b_rsp_rdata;
    logic [23:0]  b_req_wmask;
    logic         b_busy;

    int n_cmp = 0;
    int n_bad = 0;

    pmem_bridge #(.NPORT(2), .AW(64), .DW(64), .LATENCY(2)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy)
    );

    pmem_bridge #(.NPORT(3), .AW(64), .DW(64), .LATENCY(1)) u_dut3 (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_wmask(b_req_wmask),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .busy(b_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transaction on u_dut; lat counts edges from accept to rsp_valid
    task automatic txn(input int ch, input logic wr, input logic [63:0] a, input logic [63:0] d,
                       input logic [7:0] m, output int lat, output logic [1:0] rv,
                       output logic [63:0] rd);
        int w;
        req_write[ch]          = wr;
        req_addr[ch*64 +: 64]  = a;
        req_wdata[ch*64 +: 64] = d;
        req_wmask[ch*8 +: 8]   = m;
        req_valid[ch]          = 1'b1;
        #1;
        w = 0;
        while (!req_ready[ch] && w < 10) begin
            step();
            w++;
        end
        check("txn_grant", 64'(req_ready[ch]), 64'd1);
        if (!req_ready[ch]) begin
            req_valid[ch] = 1'b0;
            lat = -1;
            rv  = '0;
            rd  = '0;
            return;
        end
        step();
        req_valid[ch]          = 1'b0;
        req_addr[ch*64 +: 64]  = '1;
        req_wdata[ch*64 +: 64] = '1;
        req_wmask[ch*8 +: 8]   = '1;
        lat = 0;
        while (rsp_valid[ch] !== 1'b1 && lat < 10) begin
            step();
            lat++;
        end
        rv = rsp_valid;
        rd = rsp_rdata[ch*64 +: 64];
    endtask

    int          lat, n_acc, n_rsp, cyc, seen;
    logic [1:0]  rv;
    logic [63:0] rd;
    int unsigned c0;
    logic [1:0]  acc_ch [4];
    int          acc_cyc [4];
    int          b_acc [3];
    int          b_rsp [3];
    logic [2:0]  b_rv [3];
    logic [63:0] b_rd [3];

    initial begin
        rst = 1'b1;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_wmask = '0;
        b_req_valid = '0; b_req_write = '0; b_req_addr = '0; b_req_wdata = '0; b_req_wmask = '0;
        for (int i = 0; i < 4; i++) begin acc_ch[i] = '0; acc_cyc[i] = 0; end
        for (int i = 0; i < 3; i++) begin b_acc[i] = 0; b_rsp[i] = 0; b_rv[i] = '0; b_rd[i] = '0; end
        pmem_load(64'h8000_0000, 64'h1122_3344_5566_7788);
        pmem_load(64'h8000_0010, 64'h0123_4567_89AB_CDEF);
        pmem_load(64'h8000_0020, 64'h5555_AAAA_5555_AAAA);
        step();
        step();

        // reset state
        req_valid = 2'b11;
        #1;
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        req_valid = '0;
        rst = 1'b0;
        #1;
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rdata0", rsp_rdata[63:0], 64'd0);
        check("rst_idle_ready", 64'(req_ready), 64'd0);

        // misaligned read on ch0
        c0 = pmem_rd_cnt;
        req_write[0] = 1'b0;
        req_addr[63:0] = 64'h8000_0004;
        req_valid[0] = 1'b1;
        #1;
        check("t1_ready", 64'(req_ready), 64'b01);
        step();
        check("t1_rd_calls", 64'(pmem_rd_cnt - c0), 64'd1);
        check("t1_rd_addr", pmem_rd_addr, 64'h8000_0000);
        check("t1_busy_wait", 64'(busy), 64'd1);
        check("t1_ready_wait", 64'(req_ready), 64'd0);
        req_valid[0] = 1'b0;
        req_addr[63:0] = '1;
        step();
        check("t1_rsp_early", 64'(rsp_valid), 64'd0);
        check("t1_busy_resp", 64'(busy), 64'd1);
        step();
        check("t1_rsp_valid", 64'(rsp_valid), 64'b01);
        check("t1_rdata", rsp_rdata[63:0], 64'h1122_3344_5566_7788);
        check("t1_busy_done", 64'(busy), 64'd0);
        step();
        check("t1_rsp_pulse", 64'(rsp_valid), 64'd0);
        check("t1_rdata_hold", rsp_rdata[63:0], 64'h1122_3344_5566_7788);
        check("t1_single_call", 64'(pmem_rd_cnt - c0), 64'd1);

        // both channels held valid: round-robin from a fresh reset
        rst = 1'b1;
        #1;
        rst = 1'b0;
        req_write = 2'b00;
        req_addr[63:0]   = 64'h8000_0040;
        req_addr[127:64] = 64'h8000_0000;
        req_valid = 2'b11;
        #1;
        n_acc = 0;
        cyc = 0;
        while (n_acc < 4 && cyc < 40) begin
            if ((req_valid & req_ready) != 2'b00) begin
                acc_ch[n_acc]  = req_ready;
                acc_cyc[n_acc] = cyc;
                n_acc++;
            end
            step();
            cyc++;
        end
        req_valid = '0;
        check("t2_accepts", 64'(n_acc), 64'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("t2_grant%0d", i), 64'(acc_ch[i]), (i % 2 == 0) ? 64'b01 : 64'b10);
        for (int i = 1; i < 4; i++)
            check($sformatf("t2_gap%0d", i), 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd3);
        step(); step(); step();

        // partial write on ch1, then read back
        c0 = pmem_wr_cnt;
        txn(1, 1'b1, 64'h8000_0010, 64'hDEAD_BEEF_CAFE_F00D, 8'h0F, lat, rv, rd);
        check("t3_wr_calls", 64'(pmem_wr_cnt - c0), 64'd1);
        check("t3_wr_addr", pmem_wr_addr, 64'h8000_0010);
        check("t3_wr_lat", 64'(lat), 64'd2);
        check("t3_wr_rv", 64'(rv), 64'b10);
        check("t3_wr_rdata", rd, 64'd0);
        txn(1, 1'b0, 64'h8000_0010, 64'd0, 8'h00, lat, rv, rd);
        check("t3_rd_lat", 64'(lat), 64'd2);
        check("t3_rd_data", rd, 64'h0123_4567_CAFE_F00D);

        // zero-mask write completes without touching memory
        c0 = pmem_wr_cnt;
        txn(0, 1'b1, 64'h8000_0020, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, lat, rv, rd);
        check("t4_wr_calls", 64'(pmem_wr_cnt - c0), 64'd0);
        check("t4_lat", 64'(lat), 64'd2);
        check("t4_rv", 64'(rv), 64'b01);
        txn(0, 1'b0, 64'h8000_0024, 64'd0, 8'h00, lat, rv, rd);
        check("t4_rd_data", rd, 64'h5555_AAAA_5555_AAAA);

        // reset while waiting
        req_write[1] = 1'b0;
        req_addr[127:64] = 64'h8000_0000;
        req_valid[1] = 1'b1;
        #1;
        check("t5_ready", 64'(req_ready), 64'b10);
        step();
        req_valid[1] = 1'b0;
        check("t5_busy_pre", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("t5_busy_rst", 64'(busy), 64'd0);
        check("t5_rsp_rst", 64'(rsp_valid), 64'd0);
        check("t5_rdata_clr", rsp_rdata[127:64], 64'd0);
        step();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid != 2'b00) seen = 1;
            step();
        end
        check("t5_no_rsp", 64'(seen), 64'd0);
        req_write = 2'b00;
        req_valid = 2'b11;
        #1;
        check("t5_first_ch0", 64'(req_ready), 64'b01);
        req_valid[1] = 1'b0;
        txn(0, 1'b0, 64'h8000_0000, 64'd0, 8'h00, lat, rv, rd);
        check("t5_lat", 64'(lat), 64'd2);
        check("t5_rdata", rd, 64'h1122_3344_5566_7788);

        // LATENCY=1, three channels: back-to-back reads on ch2
        b_req_write = 3'b000;
        b_req_addr[191:128] = 64'h8000_0010;
        b_req_valid = 3'b100;
        #1;
        n_acc = 0;
        n_rsp = 0;
        cyc = 0;
        while (n_rsp < 3 && cyc < 30) begin
            if ((b_req_valid & b_req_ready) != 3'b000 && n_acc < 3) begin
                b_acc[n_acc] = cyc;
                n_acc++;
            end
            if (b_rsp_valid != 3'b000 && n_rsp < 3) begin
                b_rsp[n_rsp] = cyc;
                b_rv[n_rsp]  = b_rsp_valid;
                b_rd[n_rsp]  = b_rsp_rdata[191:128];
                n_rsp++;
            end
            step();
            cyc++;
            if (n_acc == 3) b_req_valid = '0;
        end
        b_req_valid = '0;
        check("t6_accepts", 64'(n_acc), 64'd3);
        check("t6_responses", 64'(n_rsp), 64'd3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t6_lat%0d", i), 64'(b_rsp[i] - (b_acc[i] + 1)), 64'd1);
            check($sformatf("t6_rv%0d", i), 64'(b_rv[i]), 64'b100);
            check($sformatf("t6_rdata%0d", i), b_rd[i], 64'h0123_4567_CAFE_F00D);
        end
        for (int i = 1; i < 3; i++)
            check($sformatf("t6_gap%0d", i), 64'(b_acc[i] - b_acc[i-1]), 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pmem_bridge.md
PMEM_BRIDGE -- requirements
Module: pmem_bridge

Interface
REQ-001 SHALL have parameter NPORT, default 2: number of requester channels (instruction fetch, data, ...), 1..8.
REQ-002 SHALL have parameter AW, default 64: address width in bits.
REQ-003 SHALL have parameter DW, default 64: data width in bits, a power of two from 32 to 64.
REQ-004 SHALL have parameter LATENCY, default 2: cycles from accept to response, at least 1.
REQ-005 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port req_valid  input  NPORT  per-channel request valid.
REQ-008 SHALL have port req_ready  output  NPORT  per-channel request accept.
REQ-009 SHALL have port req_write  input  NPORT  per-channel: 1 is write, 0 is read.
REQ-010 SHALL have port req_addr  input  NPORT*AW  per-channel byte address.
REQ-011 SHALL have port req_wdata  input  NPORT*DW  per-channel write data.
REQ-012 SHALL have port req_wmask  input  NPORT*(DW/8)  per-channel byte-enable mask.
REQ-013 SHALL have port rsp_valid  output  NPORT  per-channel one-cycle response pulse.
REQ-014 SHALL have port rsp_rdata  output  NPORT*DW  per-channel read data.
REQ-015 SHALL have port busy  output  1  a transaction is outstanding.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-017 SHALL have at most one transaction outstanding.
REQ-018 SHALL, in IDLE, grant by round-robin among asserted req_valid bits: search starts at the channel after the last granted one; the pointer resets to channel NPORT-1, so channel 0 wins first.
REQ-019 SHALL assert req_ready only for the granted channel and only in IDLE; all req_ready bits SHALL be 0 in WAIT and RESP.
REQ-020 SHALL accept a request on a rising edge where req_valid&req_ready is high, latching channel index, write flag, address, data and mask.
REQ-021 SHALL align the address down to a DW/8-byte boundary before the memory call.
REQ-022 SHALL, on accept of a read, call DPI pmem_read once and register the result as rd_buf.
REQ-023 SHALL, on accept of a write with a nonzero mask, call DPI pmem_write once.
REQ-024 SHALL make no DPI call for a write with an all-zero mask; that write SHALL still complete with a response.
REQ-025 SHALL never call DPI in any cycle other than an accept edge.
REQ-026 SHALL, on accept, go to RESP if LATENCY==1; otherwise go to WAIT with the counter loaded to LATENCY-2.
REQ-027 SHALL, in WAIT, decrement the counter each cycle and go to RESP when the counter is 0.
REQ-028 SHALL, in RESP, drive rsp_valid high for the latched channel only, for exactly one cycle, then return to IDLE.
REQ-029 SHALL set rsp_rdata for that channel to rd_buf on a read and to 0 on a write; the value SHALL be held until that channel's next response.
REQ-030 SHALL assert rsp_valid on the LATENCY-th rising edge after the accept edge.
REQ-031 SHALL allow a new accept no earlier than the cycle after RESP, giving a peak rate of one transaction per LATENCY+1 cycles.
REQ-032 SHALL drive busy high in WAIT and RESP only.
REQ-033 SHALL not require a requester to hold req_valid while waiting; request fields SHALL be sampled only at the accept edge.

Reset
REQ-034 SHALL, on rst, go to IDLE and clear to 0: the counter, rsp_valid, rsp_rdata, rd_buf, busy and all latched request fields.
REQ-035 SHALL, on rst mid-transaction, emit no response; a write already performed SHALL NOT be undone.
REQ-036 SHALL hold req_ready at 0 while rst is high.

Structure
REQ-037 SHALL take the FSM state enum and the DPI import declarations from shared package npc_mem_pkg.
REQ-038 SHALL place the round-robin selection in sub-module rr_arbiter with parameter N, inputs req[N] and advance, and output a one-hot grant[N].

Verification
REQ-039 SHALL cover: NPORT=2, LATENCY=2, ch0 reads addr 0x80000004 holding 0x1122334455667788 at 0x80000000 -> pmem_read called with addr 0x80000000, ch0 rsp_valid exactly 2 edges after accept, rsp_rdata = 0x1122334455667788.
REQ-040 SHALL cover: ch0 and ch1 both hold req_valid for 4 transactions -> grants alternate 0,1,0,1, with accepts spaced 3 cycles apart.
REQ-041 SHALL cover: ch1 writes 0xDEADBEEF_CAFEF00D with mask 0x0F to 0x80000010, then reads it back -> read returns the upper word unchanged and the lower word 0xCAFEF00D; the write response carries rsp_rdata = 0.
REQ-042 SHALL cover: a write with mask 0x00 -> no pmem_write call, rsp_valid still pulses after LATENCY cycles.
REQ-043 SHALL cover: rst asserted in WAIT -> no rsp_valid, busy = 0 immediately, the next request is accepted normally with channel 0 winning first.
REQ-044 SHALL cover: LATENCY=1, NPORT=3 back-to-back reads on ch2 -> each rsp_valid one edge after accept, accept rate one per 2 cycles.
